// File: rtl/mc_control_fsm.sv
// Multi-cycle control sequencer: fetch/decode/execute/memory/writeback with retire counter.
// Latency: 3 cycles (B/UJ), 4 (3R/2RI/RI/S), 5 (L) per instruction with mem_ready held high.
// Backpressure: FETCH, MEM_RD and MEM_WR hold their strobes and stall until mem_ready.
module mc_control_fsm #(
    parameter int OPC_W = 3,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [OPC_W-1:0] opcode,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IRWrite,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             reg_write,
    output logic             memToReg,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_EXEC_U, S_MEM_ADDR,
        S_MEM_RD, S_MEM_WR, S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP, S_HALT
    } state_t;

    localparam logic [OPC_W-1:0] OP_R    = OPC_W'(0);
    localparam logic [OPC_W-1:0] OP_I    = OPC_W'(1);
    localparam logic [OPC_W-1:0] OP_U    = OPC_W'(2);
    localparam logic [OPC_W-1:0] OP_LD   = OPC_W'(3);
    localparam logic [OPC_W-1:0] OP_J    = OPC_W'(4);
    localparam logic [OPC_W-1:0] OP_ST   = OPC_W'(5);
    localparam logic [OPC_W-1:0] OP_B    = OPC_W'(6);
    localparam logic [OPC_W-1:0] OP_HALT = OPC_W'(7);

    state_t             r_state;
    state_t             w_next;
    logic               r_armed;   // IDLE waits one extra edge after reset release
    logic [OPC_W-1:0]   r_opc;
    logic [CNT_W-1:0]   r_count;
    logic               w_retire;

    // State register, opcode latch, retire counter
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
            r_armed <= 1'b0;
            r_opc   <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            r_armed <= 1'b1;
            if (r_state == S_DECODE) r_opc <= opcode;
            if (w_retire) r_count <= r_count + CNT_W'(1);
        end
    end

    // Next-state selection; a retire is any return to FETCH from an instruction's last state
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (r_armed) w_next = S_FETCH;
            S_FETCH:    if (mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_R:         w_next = S_EXEC_R;
                    OP_I:         w_next = S_EXEC_I;
                    OP_U:         w_next = S_EXEC_U;
                    OP_LD, OP_ST: w_next = S_MEM_ADDR;
                    OP_J:         w_next = S_JUMP;
                    OP_B:         w_next = S_BRANCH;
                    OP_HALT:      w_next = S_HALT;
                    default:      w_next = S_HALT;
                endcase
            end
            S_EXEC_R, S_EXEC_I, S_EXEC_U: w_next = S_WB_ALU;
            S_MEM_ADDR: w_next = (r_opc == OP_LD) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (mem_ready) w_next = S_WB_MEM;
            S_MEM_WR:   if (mem_ready) w_next = S_FETCH;
            S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP: w_next = S_FETCH;
            S_HALT:     w_next = S_HALT;
            default:    w_next = S_IDLE;
        endcase
        w_retire = (w_next == S_FETCH) && (r_state != S_IDLE) && (r_state != S_FETCH);
    end

    // Moore output decode; only FETCH's PC/IR enables depend on mem_ready
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IRWrite     = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        reg_write   = 1'b0;
        memToReg    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        halted      = 1'b0;
        case (r_state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE:   ALUSrcB = 2'b10;
            S_EXEC_R: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            S_EXEC_I, S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_EXEC_U: begin
                ALUSrcB = 2'b10;
                ALUOp   = 2'b11;
            end
            S_MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_WB_ALU:   reg_write = 1'b1;
            S_WB_MEM: begin
                reg_write = 1'b1;
                memToReg  = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b01;
            end
            S_HALT:     halted = 1'b1;
            default: ;
        endcase
    end

    assign instr_count = r_count;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: directed instruction sequences push expected outputs,
// a negedge monitor pops and compares. A second instance with a 3-bit counter shows wrap.
module tb_mc_control_fsm;

    localparam int ST_IDLE = 0, ST_FETCH = 1, ST_DECODE = 2, ST_EXEC_R = 3, ST_EXEC_I = 4,
                   ST_EXEC_U = 5, ST_MEM_ADDR = 6, ST_MEM_RD = 7, ST_MEM_WR = 8,
                   ST_WB_ALU = 9, ST_WB_MEM = 10, ST_BRANCH = 11, ST_JUMP = 12, ST_HALT = 13;

    logic        CLK, RST_N, mem_ready;
    logic [2:0]  opcode;
    logic        PCWrite, PCWriteCond, IRWrite, IorD, MemRead, MemWrite, reg_write, memToReg;
    logic        ALUSrcA, halted;
    logic [1:0]  ALUSrcB, ALUOp, PCSource;
    logic [15:0] instr_count;

    logic        s_PCWrite, s_PCWriteCond, s_IRWrite, s_IorD, s_MemRead, s_MemWrite;
    logic        s_reg_write, s_memToReg, s_ALUSrcA, s_halted;
    logic [1:0]  s_ALUSrcB, s_ALUOp, s_PCSource;
    logic [2:0]  s_instr_count;

    mc_control_fsm #(.OPC_W(3), .CNT_W(16)) u_dut (
        .CLK(CLK), .RST_N(RST_N), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IRWrite(IRWrite), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .reg_write(reg_write), .memToReg(memToReg),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
        .halted(halted), .instr_count(instr_count)
    );

    mc_control_fsm #(.OPC_W(3), .CNT_W(3)) u_small (
        .CLK(CLK), .RST_N(RST_N), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(s_PCWrite), .PCWriteCond(s_PCWriteCond), .IRWrite(s_IRWrite), .IorD(s_IorD),
        .MemRead(s_MemRead), .MemWrite(s_MemWrite), .reg_write(s_reg_write),
        .memToReg(s_memToReg), .ALUSrcA(s_ALUSrcA), .ALUSrcB(s_ALUSrcB), .ALUOp(s_ALUOp),
        .PCSource(s_PCSource), .halted(s_halted), .instr_count(s_instr_count)
    );

    typedef struct {
        logic [15:0] o;
        logic [15:0] c;
        int          s;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Expected output vector per state, written from the output table
    function automatic logic [15:0] exp_o(input int s, input logic mr);
        logic pcw, pcwc, irw, iord, mrd, mwr, rw, m2r, asa, hlt;
        logic [1:0] asb, aop, pcs;
        {pcw, pcwc, irw, iord, mrd, mwr, rw, m2r, asa, hlt} = '0;
        asb = 2'b00; aop = 2'b00; pcs = 2'b00;
        case (s)
            ST_FETCH:    begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
            ST_DECODE:   asb = 2'b10;
            ST_EXEC_R:   begin asa = 1; aop = 2'b10; end
            ST_EXEC_I:   begin asa = 1; asb = 2'b10; end
            ST_EXEC_U:   begin asb = 2'b10; aop = 2'b11; end
            ST_MEM_ADDR: begin asa = 1; asb = 2'b10; end
            ST_MEM_RD:   begin mrd = 1; iord = 1; end
            ST_MEM_WR:   begin mwr = 1; iord = 1; end
            ST_WB_ALU:   rw = 1;
            ST_WB_MEM:   begin rw = 1; m2r = 1; end
            ST_BRANCH:   begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
            ST_JUMP:     begin pcw = 1; pcs = 2'b01; end
            ST_HALT:     hlt = 1;
            default: ;
        endcase
        return {pcw, pcwc, irw, iord, mrd, mwr, rw, m2r, asa, asb, aop, pcs, hlt};
    endfunction

    function automatic void push(input int s, input logic mr, input logic [15:0] c);
        exp_t e;
        e.o = exp_o(s, mr);
        e.c = c;
        e.s = s;
        q.push_back(e);
    endfunction

    // One clock of stimulus: drive inputs after the edge, record what this cycle must show
    task automatic step(input int s, input logic [2:0] op, input logic mr, input logic [15:0] c);
        @(posedge CLK);
        #1;
        opcode    = op;
        mem_ready = mr;
        push(s, mr, c);
    endtask

    // One instruction from FETCH entry; op_late is driven after DECODE. Non-memory
    // states see mem_ready low, which must not matter.
    task automatic instr(input logic [2:0] op, input logic [2:0] op_late, input int fw,
                         input int mw, input logic [15:0] c);
        for (int i = 0; i < fw; i++) step(ST_FETCH, op, 1'b0, c);
        step(ST_FETCH, op, 1'b1, c);
        step(ST_DECODE, op, 1'b0, c);
        case (op)
            3'd0: begin step(ST_EXEC_R, op_late, 1'b0, c); step(ST_WB_ALU, op_late, 1'b0, c); end
            3'd1: begin step(ST_EXEC_I, op_late, 1'b0, c); step(ST_WB_ALU, op_late, 1'b0, c); end
            3'd2: begin step(ST_EXEC_U, op_late, 1'b0, c); step(ST_WB_ALU, op_late, 1'b0, c); end
            3'd3: begin
                step(ST_MEM_ADDR, op_late, 1'b0, c);
                for (int i = 0; i < mw; i++) step(ST_MEM_RD, op_late, 1'b0, c);
                step(ST_MEM_RD, op_late, 1'b1, c);
                step(ST_WB_MEM, op_late, 1'b0, c);
            end
            3'd5: begin
                step(ST_MEM_ADDR, op_late, 1'b0, c);
                for (int i = 0; i < mw; i++) step(ST_MEM_WR, op_late, 1'b0, c);
                step(ST_MEM_WR, op_late, 1'b1, c);
            end
            3'd4: step(ST_JUMP, op_late, 1'b0, c);
            3'd6: step(ST_BRANCH, op_late, 1'b0, c);
            default: for (int i = 0; i < 3; i++) step(ST_HALT, op_late, 1'b1, c);
        endcase
    endtask

    // Monitor: every expected cycle is popped and compared away from the active edge
    always @(negedge CLK) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [15:0] act;
            e = q.pop_front();
            act = {PCWrite, PCWriteCond, IRWrite, IorD, MemRead, MemWrite, reg_write, memToReg,
                   ALUSrcA, ALUSrcB, ALUOp, PCSource, halted};
            checks++;
            if (act !== e.o) begin
                errors++;
                $display("FAIL outputs state=%0d t=%0t actual=%b required=%b", e.s, $time, act, e.o);
            end
            checks++;
            if (instr_count !== e.c) begin
                errors++;
                $display("FAIL instr_count state=%0d t=%0t actual=%h required=%h",
                         e.s, $time, instr_count, e.c);
            end
            checks++;
            if (s_instr_count !== e.c[2:0]) begin
                errors++;
                $display("FAIL wrap_count state=%0d t=%0t actual=%0d required=%0d",
                         e.s, $time, s_instr_count, e.c[2:0]);
            end
        end
    end

    initial begin
        RST_N     = 1'b0;
        opcode    = 3'd0;
        mem_ready = 1'b1;
        #2;
        push(ST_IDLE, 1'b1, 16'd0);          // under reset
        #10 RST_N = 1'b1;                     // released between edges
        step(ST_IDLE, 3'd0, 1'b1, 16'd0);     // first edge: still IDLE

        instr(3'd0, 3'd0, 0, 0, 16'd0);       // 3R
        instr(3'd3, 3'd3, 0, 2, 16'd1);       // L with two wait cycles in MEM_RD
        instr(3'd5, 3'd3, 1, 0, 16'd2);       // S, fetch wait, opcode flips to L after DECODE
        instr(3'd6, 3'd6, 0, 0, 16'd3);       // B
        instr(3'd4, 3'd4, 0, 0, 16'd4);       // UJ
        instr(3'd1, 3'd1, 0, 0, 16'd5);       // 2RI
        instr(3'd2, 3'd2, 0, 0, 16'd6);       // RI
        instr(3'd0, 3'd7, 0, 0, 16'd7);       // 3R, late opcode ignored
        instr(3'd5, 3'd5, 0, 2, 16'd8);       // S with two write waits; small counter wrapped
        instr(3'd7, 3'd7, 0, 0, 16'd9);       // HALT: absorbing, count frozen

        // Reset in the middle of a cycle: outputs must clear before the next edge
        @(posedge CLK);
        #3 RST_N = 1'b0;
        #1 push(ST_IDLE, 1'b1, 16'd0);
        #2 RST_N = 1'b1;
        step(ST_IDLE, 3'd0, 1'b1, 16'd0);
        instr(3'd6, 3'd6, 0, 0, 16'd0);
        step(ST_FETCH, 3'd0, 1'b1, 16'd1);

        repeat (2) @(negedge CLK);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
